// File: rtl/sample_decimator.sv
// sample_decimator
//   Averaging decimator: sums blocks of 2^log2_ratio valid input samples and
//   emits each block average on a valid/ready output. Downstream backpressure
//   never stalls the input side; a result that cannot be loaded is dropped
//   and counted.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   i_sample        signed input sample
//   i_sample_valid  i_sample is a new conversion this cycle
//   i_clear         pulse: clears o_overrun / o_drop_count
//   o_sample        signed block average (held while o_valid && !i_ready)
//   o_valid         o_sample holds an unconsumed result
//   i_ready         downstream accepts o_sample this cycle
//   o_overrun       sticky drop flag
//   o_drop_count    saturating count of dropped results
module sample_decimator #(
  parameter int sample_width   = 16,
  parameter int log2_ratio     = 3,
  parameter int drop_cnt_width = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic signed [sample_width-1:0]   i_sample,
  input  logic                             i_sample_valid,
  input  logic                             i_clear,
  output logic signed [sample_width-1:0]   o_sample,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_overrun,
  output logic [drop_cnt_width-1:0]        o_drop_count
);

  localparam int AW = sample_width + log2_ratio;
  // keep the block counter at least one bit wide so N=1 still elaborates
  localparam int CW = (log2_ratio > 0) ? log2_ratio : 1;
  localparam int N  = 1 << log2_ratio;

  logic signed [AW-1:0] acc, acc_next, avg;
  logic [CW-1:0]        cnt;
  logic                 last, blk, load, drop;

  always_comb begin
    acc_next = acc + AW'(i_sample);        // sign-extends (both signed)
    avg      = acc_next >>> log2_ratio;    // floor division by N
    last     = (cnt == CW'(N - 1));
    blk      = i_sample_valid && last;
    load     = blk && (!o_valid || i_ready);
    drop     = blk && o_valid && !i_ready;
  end

  // accumulator / block counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (i_sample_valid) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
      end
    end
  end

  // output register and handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_sample <= '0;
      o_valid  <= 1'b0;
    end else if (load) begin
      o_sample <= avg[sample_width-1:0];
      o_valid  <= 1'b1;
    end else if (o_valid && i_ready) begin
      o_valid  <= 1'b0;
    end
  end

  // overrun reporting; a drop in the same cycle as i_clear wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_overrun    <= 1'b0;
      o_drop_count <= '0;
    end else if (drop) begin
      o_overrun <= 1'b1;
      if (i_clear)
        o_drop_count <= drop_cnt_width'(1);
      else if (o_drop_count != '1)
        o_drop_count <= o_drop_count + drop_cnt_width'(1);
    end else if (i_clear) begin
      o_overrun    <= 1'b0;
      o_drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_sample_decimator.sv
module tb_sample_decimator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] i_sample;
  logic               i_sample_valid;
  logic               i_clear;
  logic               i_ready;
  logic signed [15:0] o_sample,  o_sample0;
  logic               o_valid,   o_valid0;
  logic               o_overrun, o_overrun0;
  logic [7:0]         o_drop_count, o_drop_count0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sample_decimator #(.sample_width(16), .log2_ratio(3), .drop_cnt_width(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_sample(i_sample), .i_sample_valid(i_sample_valid),
    .i_clear(i_clear), .o_sample(o_sample), .o_valid(o_valid), .i_ready(i_ready),
    .o_overrun(o_overrun), .o_drop_count(o_drop_count));

  // N=1 instance shares the stimulus; only checked in test_ratio1
  sample_decimator #(.sample_width(16), .log2_ratio(0), .drop_cnt_width(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_sample(i_sample), .i_sample_valid(i_sample_valid),
    .i_clear(i_clear), .o_sample(o_sample0), .o_valid(o_valid0), .i_ready(i_ready),
    .o_overrun(o_overrun0), .o_drop_count(o_drop_count0));

  // one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [15:0] v);
    i_sample       = v;
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
  endtask

  task automatic push_block(input logic signed [15:0] v);
    for (int k = 0; k < 8; k++) push(v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_sample = '0; i_sample_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b1;
    tick(); tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", o_valid); end
    checks++; if (o_sample !== 16'sh0000) begin errors++; $display("FAIL reset_sample: got %h exp 0000", o_sample); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", o_overrun); end
    checks++; if (o_drop_count !== 8'h00) begin errors++; $display("FAIL reset_dropcnt: got %h exp 00", o_drop_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    for (int k = 0; k < 7; k++) push(16'sh0100);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b exp 0", o_valid); end
    push(16'sh0100);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", o_valid); end
    checks++; if (o_sample !== 16'sh0100) begin errors++; $display("FAIL basic_sample: got %h exp 0100", o_sample); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b exp 0", o_valid); end
  endtask

  task automatic test_patterns();
    logic signed [15:0] vals [4];
    logic signed [15:0] exps [4];
    vals = '{16'shFFFF, 16'sh7FFF, 16'sh8000, 16'sh0003};
    exps = '{16'shFFFF, 16'sh7FFF, 16'sh8000, 16'sh0003};
    i_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      push_block(vals[p]);
      checks++; if (o_valid !== 1'b1 || o_sample !== exps[p]) begin
        errors++; $display("FAIL pattern_%0d: got v=%b %h exp v=1 %h", p, o_valid, o_sample, exps[p]); end
      tick();
    end
    // sum -1 -> floor(-1/8) = -1
    for (int k = 0; k < 7; k++) push(16'sh0000);
    push(16'shFFFF);
    checks++; if (o_sample !== 16'shFFFF) begin errors++; $display("FAIL floor_neg: got %h exp ffff", o_sample); end
    tick();
  endtask

  task automatic test_sparse();
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      push(16'(k));
      if (k < 8) repeat (4) tick();
      if (k == 4) begin
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL sparse_mid_valid: got %b exp 0", o_valid); end
      end
    end
    checks++; if (o_valid !== 1'b1 || o_sample !== 16'sh0004) begin
      errors++; $display("FAIL sparse_avg: got v=%b %h exp v=1 0004", o_valid, o_sample); end
    tick();
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    push_block(16'sd10);
    checks++; if (o_valid !== 1'b1 || o_sample !== 16'sd10) begin
      errors++; $display("FAIL bp_first: got v=%b %h exp v=1 000a", o_valid, o_sample); end
    push_block(16'sd20);
    checks++; if (o_valid !== 1'b1 || o_sample !== 16'sd10) begin
      errors++; $display("FAIL bp_hold: got v=%b %h exp v=1 000a", o_valid, o_sample); end
    checks++; if (o_overrun !== 1'b1 || o_drop_count !== 8'd1) begin
      errors++; $display("FAIL bp_drop: got ovr=%b cnt=%0d exp ovr=1 cnt=1", o_overrun, o_drop_count); end
    i_ready = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_xfer: got %b exp 0", o_valid); end
    i_clear = 1'b1; tick(); i_clear = 1'b0;
    checks++; if (o_overrun !== 1'b0 || o_drop_count !== 8'd0) begin
      errors++; $display("FAIL bp_clear: got ovr=%b cnt=%0d exp ovr=0 cnt=0", o_overrun, o_drop_count); end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b0;
    push_block(16'sd5);
    for (int k = 0; k < 7; k++) push(16'sd7);
    checks++; if (o_valid !== 1'b1 || o_sample !== 16'sd5) begin
      errors++; $display("FAIL b2b_hold: got v=%b %h exp v=1 0005", o_valid, o_sample); end
    i_ready = 1'b1;
    push(16'sd7);
    checks++; if (o_valid !== 1'b1 || o_sample !== 16'sd7) begin
      errors++; $display("FAIL b2b_load: got v=%b %h exp v=1 0007", o_valid, o_sample); end
    checks++; if (o_overrun !== 1'b0 || o_drop_count !== 8'd0) begin
      errors++; $display("FAIL b2b_nodrop: got ovr=%b cnt=%0d exp 0 0", o_overrun, o_drop_count); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b exp 0", o_valid); end
  endtask

  task automatic test_clear_vs_drop();
    i_ready = 1'b0;
    push_block(16'sd1);
    push_block(16'sd2);
    push_block(16'sd3);
    checks++; if (o_drop_count !== 8'd2) begin errors++; $display("FAIL cvd_two: got %0d exp 2", o_drop_count); end
    for (int k = 0; k < 7; k++) push(16'sd4);
    i_clear = 1'b1; push(16'sd4); i_clear = 1'b0;
    checks++; if (o_overrun !== 1'b1 || o_drop_count !== 8'd1) begin
      errors++; $display("FAIL cvd_drop_wins: got ovr=%b cnt=%0d exp 1 1", o_overrun, o_drop_count); end
  endtask

  task automatic test_mid_reset();
    // enters with o_valid=1, overrun set; add a partial block then reset
    for (int k = 0; k < 5; k++) push(16'sh1000);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if (o_valid !== 1'b0 || o_sample !== 16'sh0000 || o_overrun !== 1'b0 || o_drop_count !== 8'd0) begin
      errors++; $display("FAIL midrst_zero: got v=%b %h ovr=%b cnt=%0d exp all 0", o_valid, o_sample, o_overrun, o_drop_count); end
    i_ready = 1'b1;
    push_block(16'sh0020);
    checks++; if (o_valid !== 1'b1 || o_sample !== 16'sh0020) begin
      errors++; $display("FAIL midrst_clean: got v=%b %h exp v=1 0020", o_valid, o_sample); end
    tick();
  endtask

  task automatic test_saturation();
    i_ready = 1'b0;
    push_block(16'sd9);
    for (int d = 1; d <= 300; d++) begin
      push_block(16'sd11);
      if (d == 254) begin
        checks++; if (o_drop_count !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d exp 254", o_drop_count); end
      end
      if (d == 255) begin
        checks++; if (o_drop_count !== 8'hFF) begin errors++; $display("FAIL sat_255: got %0d exp 255", o_drop_count); end
      end
    end
    checks++; if (o_drop_count !== 8'hFF || o_overrun !== 1'b1) begin
      errors++; $display("FAIL sat_300: got cnt=%0d ovr=%b exp 255 1", o_drop_count, o_overrun); end
    checks++; if (o_sample !== 16'sd9) begin errors++; $display("FAIL sat_hold: got %h exp 0009", o_sample); end
    i_ready = 1'b1; i_clear = 1'b1; tick(); i_clear = 1'b0;
  endtask

  task automatic test_ratio1();
    logic signed [15:0] seq [4];
    seq = '{16'sh1234, 16'shFFFE, 16'sh8000, 16'sh7FFF};
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(seq[k]);
      checks++; if (o_valid0 !== 1'b1 || o_sample0 !== seq[k]) begin
        errors++; $display("FAIL n1_pass_%0d: got v=%b %h exp v=1 %h", k, o_valid0, o_sample0, seq[k]); end
    end
    tick();
    checks++; if (o_valid0 !== 1'b0) begin errors++; $display("FAIL n1_drain: got %b exp 0", o_valid0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_sparse();
    test_backpressure();
    test_back_to_back();
    test_clear_vs_drop();
    test_mid_reset();
    test_saturation();
    test_ratio1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_decimator.md
# sample_decimator

Averaging decimator directly downstream of the board audio input stage. It consumes the free-running, sign-converted, width-expanded ADC sample stream and sums blocks of 2^log2_ratio consecutive valid samples. Each block average is emitted on a valid/ready interface toward the effects chain at the reduced rate. Output-side backpressure never stalls the input. Overruns are dropped and reported.

## Interface
- sample_width, 16, signed width of input and output samples
- log2_ratio, 3, decimation ratio N = 2^log2_ratio; legal range 0..8
- drop_cnt_width, 8, width of saturating drop counter
- clk  input  1  single clock; output of the board PLL domain
- rst_n  input  1  reset, synchronous, active-low
- i_sample  input  sample_width  signed two's-complement sample
- i_sample_valid  input  1  i_sample is a new conversion this cycle
- i_clear  input  1  one-cycle pulse; clears o_overrun and o_drop_count
- o_sample  output  sample_width  signed block average
- o_valid  output  1  o_sample holds an unconsumed result
- i_ready  input  1  downstream accepts o_sample this cycle when o_valid=1
- o_overrun  output  1  sticky; a result was dropped
- o_drop_count  output  drop_cnt_width  number of dropped results, saturating

## Operation
- Accumulator acc is sample_width+log2_ratio bits, signed. Block counter cnt is log2_ratio bits.
- Each cycle with i_sample_valid=1:
  - acc_next = acc + sign_extend(i_sample).
  - If cnt != N-1: store acc_next and increment cnt.
  - If cnt == N-1 (block complete): result = acc_next >>> log2_ratio. The shift is arithmetic and truncates toward minus infinity. acc returns to 0 and cnt to 0.
- The result always fits sample_width, so no saturation logic is needed.
- Cycles with i_sample_valid=0 leave acc and cnt unchanged.
- Output register, on a block-complete cycle:
  - Load result if o_valid=0, or if o_valid=1 and i_ready=1 in the same cycle. In both cases o_valid=1 next cycle.
  - Otherwise (o_valid=1, i_ready=0) drop the result. o_sample is unchanged. Set o_overrun=1 and increment o_drop_count, saturating at all-ones.
- Handshake:
  - A transfer occurs when o_valid and i_ready are both 1.
  - A transfer with no block completing in the same cycle gives o_valid=0 next cycle.
  - o_sample must be stable while o_valid=1 and i_ready=0.
  - i_ready has no effect when o_valid=0.
- i_clear:
  - Zeroes o_overrun and o_drop_count next cycle.
  - If a drop occurs in the same cycle, the drop wins: o_overrun=1 and o_drop_count=1.
- log2_ratio=0: every valid sample is a block. Output equals input with one cycle of latency.

## Timing
- Reset (rst_n=0 at a clk edge) forces, next cycle: acc=0, cnt=0, o_sample=0, o_valid=0, o_overrun=0, o_drop_count=0. This applies mid-block; a partial sum is discarded.
- Latency: the result is on o_sample with o_valid=1 one cycle after the clock edge that samples the N-th valid input of the block.
- Throughput: one result per N valid inputs. Back-to-back valid inputs are legal; with N=1 that is one result per cycle.
- No combinational path from i_ready or i_sample to any output. All outputs are registered.

## Test plan
- Reset, N=8, eight valid 16'sh0100 back-to-back, i_ready=1 -> o_valid=1 for one cycle, o_sample=16'sh0100, one cycle after the 8th sample.
- Eight valid 16'shFFFF (-1) -> sum -8, o_sample=16'shFFFF. Eight samples 7 x 16'sh0000 plus 1 x 16'shFFFF -> sum -1, o_sample=16'shFFFF (floor). Eight 16'sh7FFF -> 16'sh7FFF. Eight 16'sh8000 -> 16'sh8000.
- Sparse input with i_sample_valid=1 every 5th cycle, values 1..8 -> o_sample=4 (36>>>3). There is no change in acc on invalid cycles.
- i_ready=0, two full blocks (averages 10 then 20) -> o_sample stays 10 with o_valid=1. Second result dropped: o_overrun=1, o_drop_count=1. Raise i_ready -> 10 transferred, o_valid=0. Pulse i_clear -> o_overrun=0, o_drop_count=0.
- Hold o_valid=1 with i_ready=1 exactly on the next block-complete cycle -> old result transferred and new result loaded. o_valid stays 1, no drop.
- Feed 5 valid samples of 16'sh1000, assert rst_n=0 for one cycle, then eight valid 16'sh0020 -> all outputs zero after reset. The next result is 16'sh0020, unaffected by the partial sum. Drive 300 drops with drop_cnt_width=8 -> o_drop_count saturates at 8'hFF.
